mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the instruction-fetch port and the MEM-stage port
// onto one byte-wide RAM with a one-cycle read latency.
//
// Ports
//   clk_in, rst_in         clock, asynchronous active-low reset
//   rdy_in                 global enable; low freezes every register (the RAM
//                          is clock-enabled by the same signal)
//   if_req/if_addr         instruction fetch request (always a 4-byte read)
//   if_fin/if_data         fetch completion pulse and fetched word
//   memctl_op/len/addr/data  MEM-stage request (op 01 load, 10 save)
//   memctl_fin/memctl_out  MEM-stage completion pulse and loaded value
//   mem_din/mem_dout/mem_a/mem_wr  byte-wide RAM port (mem_wr=1 writes)
//
// A MEM request wins over a fetch in the same IDLE cycle. Loads are
// little-endian and zero-extended; sign extension is the MEM stage's job.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_fin,
    output logic [31:0] if_data,
    input  logic [1:0]  memctl_op,
    input  logic [1:0]  memctl_len,
    input  logic [31:0] memctl_addr,
    input  logic [31:0] memctl_data,
    output logic        memctl_fin,
    output logic [31:0] memctl_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SAVE = 2'b10;

    state_t      state, next_state;
    logic [31:0] addr_q, data_q;
    logic [31:0] rbuf_q, rbuf_d;     // read assembly buffer
    logic [2:0]  len_q;              // byte count n: 1, 2 or 4
    logic [2:0]  cnt_q;              // bytes issued so far
    logic        from_if_q;          // requester: 1 = fetch port
    logic        mem_req, accept_mem, accept_if;
    logic [2:0]  req_n;
    logic [1:0]  cap_idx;
    logic [31:0] cur_a;

    assign mem_req = (memctl_op == OP_LOAD) || (memctl_op == OP_SAVE);
    assign cur_a   = addr_q + {29'd0, cnt_q};   // wraps naturally at 2^32
    // With latency 1, the byte on mem_din belongs to the address issued
    // one step earlier, i.e. index cnt_q-1.
    assign cap_idx = cnt_q[1:0] - 2'd1;

    always_comb begin
        case (memctl_len)
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept_mem = 1'b0;
        accept_if  = 1'b0;
        mem_a      = 32'd0;
        mem_dout   = 8'd0;
        mem_wr     = 1'b0;
        rbuf_d     = rbuf_q;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    accept_mem = 1'b1;
                    next_state = (memctl_op == OP_LOAD) ? READ : WRITE;
                end else if (if_req) begin
                    accept_if  = 1'b1;
                    next_state = READ;
                end
            end
            READ: begin
                // n issue cycles plus one trailing cycle to catch the last byte
                if (cnt_q < len_q) mem_a = cur_a;
                if (cnt_q != 3'd0) rbuf_d[{cap_idx, 3'b000} +: 8] = mem_din;
                if (cnt_q == len_q) next_state = DONE;
            end
            WRITE: begin
                mem_a    = cur_a;
                mem_dout = data_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in;
                if (cnt_q == len_q - 3'd1) next_state = DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (!rdy_in) begin
            next_state = state;
            accept_mem = 1'b0;
            accept_if  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            rbuf_q     <= 32'd0;
            len_q      <= 3'd0;
            cnt_q      <= 3'd0;
            from_if_q  <= 1'b0;
            if_fin     <= 1'b0;
            memctl_fin <= 1'b0;
            if_data    <= 32'd0;
            memctl_out <= 32'd0;
        end else if (rdy_in) begin
            if_fin     <= 1'b0;
            memctl_fin <= 1'b0;
            if (accept_mem) begin
                addr_q    <= memctl_addr;
                data_q    <= memctl_data;
                len_q     <= req_n;
                from_if_q <= 1'b0;
                cnt_q     <= 3'd0;
                rbuf_q    <= 32'd0;
            end else if (accept_if) begin
                addr_q    <= if_addr;
                data_q    <= 32'd0;
                len_q     <= 3'd4;
                from_if_q <= 1'b1;
                cnt_q     <= 3'd0;
                rbuf_q    <= 32'd0;
            end else if (state == READ || state == WRITE) begin
                cnt_q  <= cnt_q + 3'd1;
                rbuf_q <= rbuf_d;
            end else if (state == DONE) begin
                cnt_q <= 3'd0;
            end
            // fin and result are registered on entry to DONE so both are
            // valid for exactly the DONE cycle
            if (next_state == DONE && state != DONE) begin
                if (from_if_q) if_fin     <= 1'b1;
                else           memctl_fin <= 1'b1;
                if (state == READ) begin
                    if (from_if_q) if_data    <= rbuf_d;
                    else           memctl_out <= rbuf_d;
                end
            end
        end
    end
endmodule
